// File: rtl/fpmul_sched_pkg.sv
// Shared definitions for the two-requester FP multiplier scheduler:
// FSM encoding, IEEE754 single-precision field widths and common constants.
package fpmul_sched_pkg;

    // FSM encoding (2-bit)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        CAPTURE = ST_CAPTURE,
        RESP    = ST_RESP
    } state_t;

    // IEEE754 single-precision field widths
    localparam int FP_SIGN_W = 1;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;
    localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

    // Handy encodings
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F800000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpmul_sched_if.sv
// Requester/response bus of the FP multiplier scheduler.
//
// Handshake rule for every channel on this bus: a transfer happens on the
// rising clock edge where valid and ready are both high. The producer keeps
// valid and its payload stable until that edge; ready may depend
// combinationally on valid, but valid never depends on ready.
interface fpmul_sched_if;
    import fpmul_sched_pkg::*;

    // Requester 0
    logic            req0_valid;
    logic [FP_W-1:0] req0_a;
    logic [FP_W-1:0] req0_b;
    logic            req0_ready;

    // Requester 1
    logic            req1_valid;
    logic [FP_W-1:0] req1_a;
    logic [FP_W-1:0] req1_b;
    logic            req1_ready;

    // Response
    logic            rsp_valid;
    logic            rsp_id;
    logic [FP_W-1:0] rsp_result;
    logic            rsp_ready;

    // Status
    logic            busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/fpmul_sched_nhan.sv
// nhan: combinational IEEE754 single-precision multiplier.
// Subnormal inputs are flushed to zero, results that underflow become signed
// zero, rounding is round-to-nearest-even, invalid operations (NaN input or
// Inf x 0) return the canonical quiet NaN.
module nhan
    import fpmul_sched_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] result
);

    logic                w_sign;
    logic [FP_EXP_W-1:0] w_ea, w_eb;
    logic [FP_MAN_W-1:0] w_ma, w_mb;
    logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [47:0]         w_prod;
    logic                w_norm;
    logic [FP_MAN_W-1:0] w_man;
    logic                w_rnd, w_stk, w_rup;
    logic signed [9:0]   w_exp;
    logic [30:0]         w_mag;

    // Field decode, significand product, normalisation, rounding and special cases
    always_comb begin
        w_sign   = a[FP_W-1] ^ b[FP_W-1];
        w_ea     = a[FP_W-2 -: FP_EXP_W];
        w_eb     = b[FP_W-2 -: FP_EXP_W];
        w_ma     = a[FP_MAN_W-1:0];
        w_mb     = b[FP_MAN_W-1:0];
        w_a_zero = (w_ea == 8'h00);
        w_b_zero = (w_eb == 8'h00);
        w_a_inf  = (w_ea == 8'hFF) && (w_ma == '0);
        w_b_inf  = (w_eb == 8'hFF) && (w_mb == '0);
        w_a_nan  = (w_ea == 8'hFF) && (w_ma != '0);
        w_b_nan  = (w_eb == 8'hFF) && (w_mb != '0);

        w_prod = {24'b0, 1'b1, w_ma} * {24'b0, 1'b1, w_mb};
        w_norm = w_prod[47];
        if (w_norm) begin
            w_man = w_prod[46:24];
            w_rnd = w_prod[23];
            w_stk = |w_prod[22:0];
        end else begin
            w_man = w_prod[45:23];
            w_rnd = w_prod[22];
            w_stk = |w_prod[21:0];
        end
        w_exp = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127
              + $signed({9'b0, w_norm});
        w_rup = w_rnd & (w_stk | w_man[0]);
        // A mantissa carry out of rounding ripples into the exponent field.
        w_mag = {w_exp[7:0], w_man} + {30'b0, w_rup};

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
            result = FP_QNAN;
        else if (w_a_inf || w_b_inf)
            result = {w_sign, 8'hFF, 23'h0};
        else if (w_a_zero || w_b_zero)
            result = {w_sign, 31'h0};
        else if (w_exp <= 10'sd0)
            result = {w_sign, 31'h0};
        else if (w_exp >= 10'sd255)
            result = {w_sign, 8'hFF, 23'h0};
        else
            result = {w_sign, w_mag};
    end

endmodule

// File: rtl/fpmul_sched.sv
// fpmul_sched: shares one combinational FP multiplier between two requesters.
// One operation is in flight at a time: grant in IDLE, hold operands during
// ISSUE, register the product in CAPTURE, present it in RESP until accepted.
module fpmul_sched
    import fpmul_sched_pkg::*;
#(
    parameter int MUL_WAIT = 1  // 1..7
) (
    input  logic          clk,
    input  logic          rst_n,
    fpmul_sched_if.slave  bus,
    output state_t        o_dbg_state
);

    localparam logic [2:0] CNT_INIT = 3'(MUL_WAIT);

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic            r_last;       // id granted most recently
    logic            r_id;         // id of the operation in flight
    logic [FP_W-1:0] r_a;
    logic [FP_W-1:0] r_b;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [FP_W-1:0] r_rsp_result;

    logic            w_any_valid;
    logic            w_grant_id;
    logic            w_accept;
    logic [FP_W-1:0] w_product;

    // Round-robin pick: on a tie the requester not granted last wins
    always_comb begin
        w_any_valid = bus.req0_valid | bus.req1_valid;
        w_grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            w_grant_id = ~r_last;
        else if (bus.req1_valid)
            w_grant_id = 1'b1;
        // Gated by rst_n so ready stays low while reset is held.
        w_accept = rst_n && (r_state == IDLE) && w_any_valid;
    end

    assign bus.req0_ready = w_accept & ~w_grant_id;
    assign bus.req1_ready = w_accept &  w_grant_id;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.busy       = (r_state != IDLE);
    assign o_dbg_state    = r_state;

    // Shared multiplier, fed only from the operand registers
    nhan u_nhan (
        .a      (r_a),
        .b      (r_b),
        .result (w_product)
    );

    // Scheduler FSM with its operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_last       <= 1'b1;   // so requester 0 wins the first tie
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant_id ? bus.req1_a : bus.req0_a;
                        r_b     <= w_grant_id ? bus.req1_b : bus.req0_b;
                        r_id    <= w_grant_id;
                        r_last  <= w_grant_id;
                        r_cnt   <= CNT_INIT;
                        r_state <= ISSUE;
                    end
                end
                // First ISSUE cycle presents the operands, then MUL_WAIT
                // further cycles are counted down before sampling.
                ISSUE: begin
                    if (r_cnt == 3'd0)
                        r_state <= CAPTURE;
                    else
                        r_cnt <= r_cnt - 3'd1;
                end
                CAPTURE: begin
                    r_rsp_result <= w_product;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_sched.sv
// Directed bench for fpmul_sched (MUL_WAIT = 1).
module tb_fpmul_sched;
    import fpmul_sched_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    int grant_q[$];
    int dbl_cnt   = 0;
    int bad_ready = 0;

    // Clock and reset
    always #5 clk = ~clk;

    fpmul_sched_if bus_if ();

    fpmul_sched #(.MUL_WAIT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // Handshake monitor, sampled 1 ns before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (bus_if.req0_valid && bus_if.req0_ready) grant_q.push_back(0);
            if (bus_if.req1_valid && bus_if.req1_ready) grant_q.push_back(1);
            if (bus_if.req0_ready && bus_if.req1_ready) dbl_cnt++;
            if (bus_if.busy && (bus_if.req0_ready || bus_if.req1_ready)) bad_ready++;
        end
    end

    // Driver tasks
    task automatic drive_idle();
        bus_if.req0_valid = 1'b0; bus_if.req0_a = '0; bus_if.req0_b = '0;
        bus_if.req1_valid = 1'b0; bus_if.req1_a = '0; bus_if.req1_b = '0;
        bus_if.rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (bus_if.rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack_rsp();
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
    endtask

    // Reset values, with requesters asserting valid during reset
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus_if.req0_valid = 1'b1; bus_if.req1_valid = 1'b1; bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.req0_ready, bus_if.req1_ready, bus_if.busy} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus_if.rsp_valid, bus_if.rsp_id, bus_if.req0_ready, bus_if.req1_ready, bus_if.busy});
        end else n_pass++;
        n_total++;
        if (bus_if.rsp_result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", bus_if.rsp_result);
        else n_pass++;
        n_total++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want 0", dbg_state);
        else n_pass++;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One request from requester 0: 1.0 x 1.0
    task automatic test_single();
        int cyc;
        grant_q.delete();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = FP_ONE; bus_if.req0_b = FP_ONE;
        #1;
        n_total++;
        if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10)
            $display("FAIL single_ready: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready});
        else n_pass++;
        @(negedge clk);
        bus_if.req0_valid = 1'b0;
        #1;
        n_total++;
        if ({bus_if.busy, bus_if.req0_ready} !== 2'b10)
            $display("FAIL single_busy: got %b want 10", {bus_if.busy, bus_if.req0_ready});
        else n_pass++;
        wait_rsp(cyc);
        n_total++;
        if (cyc != 3) $display("FAIL single_latency: got %0d want 3", cyc);
        else n_pass++;
        n_total++;
        if ({bus_if.rsp_id, bus_if.rsp_result} !== {1'b0, 32'h3F800000})
            $display("FAIL single_rsp: got id=%b res=%h want id=0 res=3f800000", bus_if.rsp_id, bus_if.rsp_result);
        else n_pass++;
        n_total++;
        if (grant_q.size() != 1) $display("FAIL single_grant_count: got %0d want 1", grant_q.size());
        else n_pass++;
        ack_rsp();
        n_total++;
        if ({bus_if.rsp_valid, bus_if.busy} !== 2'b00)
            $display("FAIL single_done: got %b want 00", {bus_if.rsp_valid, bus_if.busy});
        else n_pass++;
    endtask

    // Tie straight after reset: 1.5 x 1.75 = 2.625 from both requesters
    task automatic test_tie();
        int cyc;
        do_reset();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = 32'h3FC00000; bus_if.req0_b = 32'h3FE00000;
        bus_if.req1_valid = 1'b1; bus_if.req1_a = 32'h3FC00000; bus_if.req1_b = 32'h3FE00000;
        #1;
        n_total++;
        if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10)
            $display("FAIL tie_first_ready: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready});
        else n_pass++;
        @(negedge clk);
        bus_if.req0_valid = 1'b0;
        wait_rsp(cyc);
        n_total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result} !== {1'b1, 1'b0, 32'h40280000})
            $display("FAIL tie_rsp0: got v=%b id=%b res=%h want v=1 id=0 res=40280000",
                     bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result);
        else n_pass++;
        ack_rsp();
        #1;
        n_total++;
        if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b01)
            $display("FAIL tie_second_ready: got %b want 01", {bus_if.req0_ready, bus_if.req1_ready});
        else n_pass++;
        @(negedge clk);
        bus_if.req1_valid = 1'b0;
        wait_rsp(cyc);
        n_total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result} !== {1'b1, 1'b1, 32'h40280000})
            $display("FAIL tie_rsp1: got v=%b id=%b res=%h want v=1 id=1 res=40280000",
                     bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result);
        else n_pass++;
        ack_rsp();
    endtask

    // Both requesters held valid for six operations: grants must alternate
    task automatic test_fairness();
        int cyc;
        logic [31:0] exp_res;
        grant_q.delete();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = 32'h40000000; bus_if.req0_b = 32'h40400000; // 2*3 = 6
        bus_if.req1_valid = 1'b1; bus_if.req1_a = FP_ONE;       bus_if.req1_b = 32'h40400000; // 1*3 = 3
        for (int i = 0; i < 6; i++) begin
            wait_rsp(cyc);
            exp_res = (i % 2 == 0) ? 32'h40C00000 : 32'h40400000;
            n_total++;
            if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result} !== {1'b1, 1'(i % 2), exp_res})
                $display("FAIL fair_rsp%0d: got v=%b id=%b res=%h want v=1 id=%0d res=%h",
                         i, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, i % 2, exp_res);
            else n_pass++;
            if (i == 5) begin
                bus_if.req0_valid = 1'b0;
                bus_if.req1_valid = 1'b0;
            end
            ack_rsp();
        end
        n_total++;
        if (grant_q.size() != 6) $display("FAIL fair_grant_count: got %0d want 6", grant_q.size());
        else n_pass++;
        for (int i = 0; i < grant_q.size() && i < 6; i++) begin
            n_total++;
            if (grant_q[i] != i % 2) $display("FAIL fair_grant%0d: got %0d want %0d", i, grant_q[i], i % 2);
            else n_pass++;
        end
        n_total++;
        if (dbl_cnt != 0) $display("FAIL fair_double_grant: got %0d want 0", dbl_cnt);
        else n_pass++;
    endtask

    // rsp_ready held low for 10 cycles with requester inputs toggling
    task automatic test_backpressure();
        int cyc;
        int bad;
        grant_q.delete();
        bus_if.req0_valid = 1'b1; bus_if.req0_a = 32'h40000000; bus_if.req0_b = 32'h40400000;
        @(negedge clk);
        bus_if.req0_valid = 1'b0;
        wait_rsp(cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus_if.req1_valid = 1'b1;
            bus_if.req0_a = $urandom; bus_if.req0_b = $urandom;
            bus_if.req1_a = $urandom; bus_if.req1_b = $urandom;
            #1;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_id !== 1'b0 || bus_if.rsp_result !== 32'h40C00000 ||
                bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0 || bus_if.busy !== 1'b1)
                bad++;
            @(negedge clk);
        end
        bus_if.req1_valid = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        ack_rsp();
        n_total++;
        if ({bus_if.rsp_valid, bus_if.busy, dbg_state} !== {2'b00, IDLE})
            $display("FAIL bp_release: got v=%b busy=%b st=%0d want 0 0 0", bus_if.rsp_valid, bus_if.busy, dbg_state);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus_if.busy !== 1'b0 || grant_q.size() != 1)
            $display("FAIL bp_no_latch: got busy=%b grants=%0d want busy=0 grants=1", bus_if.busy, grant_q.size());
        else n_pass++;
    endtask

    // Reset pulse during ISSUE aborts the operation
    task automatic test_mid_reset();
        int seen;
        bus_if.req0_valid = 1'b1; bus_if.req0_a = FP_ONE; bus_if.req0_b = 32'h40000000;
        @(negedge clk);
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.req0_ready, bus_if.req1_ready, bus_if.busy} !== 5'b0)
            $display("FAIL midrst_ctrl: got %b want 00000",
                     {bus_if.rsp_valid, bus_if.rsp_id, bus_if.req0_ready, bus_if.req1_ready, bus_if.busy});
        else n_pass++;
        n_total++;
        if (bus_if.rsp_result !== 32'h0 || dbg_state !== IDLE)
            $display("FAIL midrst_regs: got res=%h st=%0d want 00000000 0", bus_if.rsp_result, dbg_state);
        else n_pass++;
        bus_if.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid !== 1'b0 || bus_if.busy !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL midrst_no_rsp: got %0d active cycles want 0", seen);
        else n_pass++;
        bus_if.req0_valid = 1'b1;
        bus_if.req1_valid = 1'b1;
        #1;
        n_total++;
        if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10)
            $display("FAIL midrst_tie: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready});
        else n_pass++;
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        @(negedge clk);
    endtask

    // Special encodings, with operand inputs changing while the op is in flight
    task automatic test_special();
        int cyc;
        logic [31:0] va [4] = '{32'h7F800000, 32'h3F800000, 32'hC0000000, 32'h80000000};
        logic [31:0] vb [4] = '{32'h00000000, 32'hFF800000, 32'h40400000, 32'h3F800000};
        logic [31:0] vr [4] = '{32'h7FC00000, 32'hFF800000, 32'hC0C00000, 32'h80000000};
        for (int i = 0; i < 4; i++) begin
            bus_if.req0_valid = 1'b1; bus_if.req0_a = va[i]; bus_if.req0_b = vb[i];
            @(negedge clk);
            bus_if.req0_valid = 1'b0;
            bus_if.req0_a = ~va[i]; bus_if.req0_b = 32'h3F800000;
            bus_if.req1_a = 32'h40000000; bus_if.req1_b = 32'h40000000;
            wait_rsp(cyc);
            n_total++;
            if ({bus_if.rsp_valid, bus_if.rsp_result} !== {1'b1, vr[i]})
                $display("FAIL special%0d: got v=%b res=%h want v=1 res=%h", i, bus_if.rsp_valid, bus_if.rsp_result, vr[i]);
            else n_pass++;
            ack_rsp();
        end
    endtask

    // Protocol counters accumulated over the whole run
    task automatic test_protocol();
        n_total++;
        if (bad_ready != 0) $display("FAIL ready_outside_idle: got %0d want 0", bad_ready);
        else n_pass++;
        n_total++;
        if (dbl_cnt != 0) $display("FAIL double_grant: got %0d want 0", dbl_cnt);
        else n_pass++;
    endtask

    // Sequencer and final report
    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_special();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
